// File: rtl/wb_pkg.sv
// wb_pkg: shared state enum, default widths and Wishbone request struct
package wb_pkg;
  localparam int WB_ADDR_W = 32;
  localparam int WB_DATA_W = 32;
  localparam int WB_SEL_W = WB_DATA_W / 8;
  localparam int WB_TIMEOUT = 255;
  localparam int WB_TO_W = 8;
  localparam int WB_CNT_W = 16;
  typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;
  typedef struct packed {
    logic                 we;
    logic [WB_ADDR_W-1:0] adr;
    logic [WB_DATA_W-1:0] dat;
    logic [WB_SEL_W-1:0]  sel;
  } wb_req_t;
endpackage

// File: rtl/wb_cmd_master.sv
// wb_cmd_master: single-command Wishbone classic initiator with timeout and response channel
module wb_cmd_master
  import wb_pkg::*;
#(
  parameter int ADDR_W = WB_ADDR_W,
  parameter int DATA_W = WB_DATA_W,
  parameter int TIMEOUT = WB_TIMEOUT,
  parameter int TO_W = WB_TO_W,
  parameter int CNT_W = WB_CNT_W,
  localparam int SEL_W = DATA_W / 8
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  input  logic              cmd_valid_i,
  output logic              cmd_ready_o,
  input  logic              cmd_we_i,
  input  logic [ADDR_W-1:0] cmd_adr_i,
  input  logic [DATA_W-1:0] cmd_dat_i,
  input  logic [SEL_W-1:0]  cmd_sel_i,
  output logic              rsp_valid_o,
  input  logic              rsp_ready_i,
  output logic [DATA_W-1:0] rsp_dat_o,
  output logic              rsp_err_o,
  output logic              wbm_cyc_o,
  output logic              wbm_stb_o,
  output logic              wbm_we_o,
  output logic [ADDR_W-1:0] wbm_adr_o,
  output logic [DATA_W-1:0] wbm_dat_o,
  output logic [SEL_W-1:0]  wbm_sel_o,
  input  logic              wbm_ack_i,
  input  logic [DATA_W-1:0] wbm_dat_i,
  output logic              busy_o,
  output logic [CNT_W-1:0]  txn_cnt_o
);
  state_t state_q, state_d;
  logic [TO_W-1:0] to_q, to_d;
  logic [CNT_W-1:0] cnt_d;
  logic [DATA_W-1:0] rsp_dat_d, dat_d;
  logic [ADDR_W-1:0] adr_d;
  logic [SEL_W-1:0] sel_d;
  logic cyc_d, stb_d, we_d, rsp_valid_d, rsp_err_d, expired;
  assign expired = to_q == TO_W'(TIMEOUT - 1);
  always_comb begin
    state_d = state_q;
    to_d = to_q;
    cnt_d = txn_cnt_o;
    cyc_d = wbm_cyc_o;
    stb_d = wbm_stb_o;
    we_d = wbm_we_o;
    adr_d = wbm_adr_o;
    dat_d = wbm_dat_o;
    sel_d = wbm_sel_o;
    rsp_valid_d = rsp_valid_o;
    rsp_dat_d = rsp_dat_o;
    rsp_err_d = rsp_err_o;
    case (state_q)
      IDLE: if (cmd_valid_i && cmd_ready_o) begin
        state_d = BUS;
        cyc_d = 1'b1;
        stb_d = 1'b1;
        we_d = cmd_we_i;
        adr_d = cmd_adr_i;
        dat_d = cmd_dat_i;
        sel_d = cmd_sel_i;
        to_d = '0;
      end
      BUS: begin
        to_d = to_q + 1'b1;
        if (wbm_ack_i || expired) begin
          state_d = RESP;
          cyc_d = 1'b0;
          stb_d = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_err_d = !wbm_ack_i;
          rsp_dat_d = (wbm_ack_i && !wbm_we_o) ? wbm_dat_i : '0;
          cnt_d = wbm_ack_i ? txn_cnt_o + 1'b1 : txn_cnt_o;
        end
      end
      RESP: if (rsp_ready_i) begin
        state_d = IDLE;
        rsp_valid_d = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q <= IDLE;
      to_q <= '0;
      cmd_ready_o <= 1'b0;
      busy_o <= 1'b0;
      txn_cnt_o <= '0;
      wbm_cyc_o <= 1'b0;
      wbm_stb_o <= 1'b0;
      wbm_we_o <= 1'b0;
      wbm_adr_o <= '0;
      wbm_dat_o <= '0;
      wbm_sel_o <= '0;
      rsp_valid_o <= 1'b0;
      rsp_dat_o <= '0;
      rsp_err_o <= 1'b0;
    end else begin
      state_q <= state_d;
      to_q <= to_d;
      cmd_ready_o <= state_d == IDLE;
      busy_o <= state_d != IDLE;
      txn_cnt_o <= cnt_d;
      wbm_cyc_o <= cyc_d;
      wbm_stb_o <= stb_d;
      wbm_we_o <= we_d;
      wbm_adr_o <= adr_d;
      wbm_dat_o <= dat_d;
      wbm_sel_o <= sel_d;
      rsp_valid_o <= rsp_valid_d;
      rsp_dat_o <= rsp_dat_d;
      rsp_err_o <= rsp_err_d;
    end
  end
endmodule

// File: tb/tb_wb_cmd_master.sv
// tb_wb_cmd_master: directed self-checking bench for wb_cmd_master
module tb_wb_cmd_master;
  import wb_pkg::*;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic cmd_valid = 1'b0, cmd_ready, cmd_we = 1'b0;
  logic [31:0] cmd_adr = '0, cmd_dat = '0;
  logic [3:0] cmd_sel = '0;
  logic rsp_valid, rsp_ready = 1'b0, rsp_err;
  logic [31:0] rsp_dat;
  logic cyc, stb, we, ack = 1'b0, busy;
  logic [31:0] adr, dat_o, dat_i = '0;
  logic [3:0] sel;
  logic [15:0] txn_cnt;
  int n_chk = 0, n_pass = 0;
  wb_req_t exp_req;
  always #5 clk = ~clk;
  wb_cmd_master #(.TIMEOUT(4)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_we_i(cmd_we),
    .cmd_adr_i(cmd_adr), .cmd_dat_i(cmd_dat), .cmd_sel_i(cmd_sel),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_dat_o(rsp_dat), .rsp_err_o(rsp_err),
    .wbm_cyc_o(cyc), .wbm_stb_o(stb), .wbm_we_o(we), .wbm_adr_o(adr),
    .wbm_dat_o(dat_o), .wbm_sel_o(sel), .wbm_ack_i(ack), .wbm_dat_i(dat_i),
    .busy_o(busy), .txn_cnt_o(txn_cnt)
  );
  task automatic chk(input string tag, input logic [71:0] got, input logic [71:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic issue(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    cmd_valid = 1'b1;
    cmd_we = w;
    cmd_adr = a;
    cmd_dat = d;
    cmd_sel = s;
    step();
    cmd_valid = 1'b0;
    cmd_we = ~w;
    cmd_adr = 32'hFFFF_FFFF;
    cmd_dat = 32'hA5A5_A5A5;
    cmd_sel = 4'h0;
  endtask
  task automatic consume();
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    chk("rsp_valid_cleared", rsp_valid, 0);
    chk("ready_after_rsp", cmd_ready, 1);
  endtask
  initial begin
    step();
    step();
    chk("rst_ready", cmd_ready, 0);
    chk("rst_cyc", cyc, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_cnt", txn_cnt, 0);
    chk("rst_busy", busy, 0);
    rst = 1'b0;
    step();
    chk("ready_after_rst", cmd_ready, 1);
    issue(1'b0, 32'h3000_0004, 32'h0, 4'hF);
    for (int k = 1; k <= 3; k++) begin
      chk("rd_cyc", cyc, 1);
      chk("rd_stb", stb, 1);
      chk("rd_adr", adr, 32'h3000_0004);
      chk("rd_busy", busy, 1);
      chk("rd_ready_low", cmd_ready, 0);
      if (k == 3) begin
        ack = 1'b1;
        dat_i = 32'hDEAD_BEEF;
      end
      step();
    end
    ack = 1'b0;
    chk("rd_stb_drop", stb, 0);
    chk("rd_cyc_drop", cyc, 0);
    chk("rd_rsp_valid", rsp_valid, 1);
    chk("rd_rsp_dat", rsp_dat, 32'hDEAD_BEEF);
    chk("rd_rsp_err", rsp_err, 0);
    chk("rd_cnt", txn_cnt, 1);
    consume();
    issue(1'b1, 32'h3000_0000, 32'h1234_5678, 4'h3);
    exp_req = '{we: 1'b1, adr: 32'h3000_0000, dat: 32'h1234_5678, sel: 4'h3};
    for (int k = 1; k <= 2; k++) begin
      chk("wr_req", {we, adr, dat_o, sel}, exp_req);
      chk("wr_stb", stb, 1);
      if (k == 2) begin
        ack = 1'b1;
        dat_i = 32'h5555_AAAA;
      end
      step();
    end
    ack = 1'b0;
    chk("wr_rsp_valid", rsp_valid, 1);
    chk("wr_rsp_dat", rsp_dat, 0);
    chk("wr_rsp_err", rsp_err, 0);
    chk("wr_cnt", txn_cnt, 2);
    consume();
    issue(1'b0, 32'h3000_0008, 32'h0, 4'hF);
    for (int k = 1; k <= 4; k++) begin
      chk("to_stb", stb, 1);
      step();
    end
    chk("to_stb_drop", stb, 0);
    chk("to_rsp_valid", rsp_valid, 1);
    chk("to_rsp_err", rsp_err, 1);
    chk("to_rsp_dat", rsp_dat, 0);
    chk("to_cnt", txn_cnt, 2);
    consume();
    issue(1'b0, 32'h3000_000C, 32'h0, 4'hF);
    for (int k = 1; k <= 4; k++) begin
      chk("tie_stb", stb, 1);
      if (k == 4) begin
        ack = 1'b1;
        dat_i = 32'hCAFE_F00D;
      end
      step();
    end
    ack = 1'b0;
    chk("tie_rsp_err", rsp_err, 0);
    chk("tie_rsp_dat", rsp_dat, 32'hCAFE_F00D);
    chk("tie_cnt", txn_cnt, 3);
    for (int k = 1; k <= 5; k++) begin
      ack = k == 2;
      dat_i = 32'h0BAD_0BAD;
      step();
      chk("bp_rsp_valid", rsp_valid, 1);
      chk("bp_rsp_dat", rsp_dat, 32'hCAFE_F00D);
      chk("bp_cmd_ready", cmd_ready, 0);
      chk("bp_cyc", cyc, 0);
    end
    ack = 1'b0;
    chk("bp_cnt", txn_cnt, 3);
    consume();
    issue(1'b0, 32'h3000_0010, 32'h0, 4'hF);
    chk("rb_cyc", cyc, 1);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rb_cyc_low", cyc, 0);
    chk("rb_stb_low", stb, 0);
    chk("rb_rsp_valid", rsp_valid, 0);
    chk("rb_cnt", txn_cnt, 0);
    step();
    chk("rb_ready", cmd_ready, 1);
    chk("rb_busy", busy, 0);
    chk("rb_rsp_valid_after", rsp_valid, 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
